// File: rtl/multi_tick_gen_if.sv
// rtl/multi_tick_gen_if.sv - configuration/enable/trigger bundle and tick outputs for multi_tick_gen (TICK_GEN_SQUARE_EN adds sq_out)
interface multi_tick_gen_if #(
    parameter int NCH   = 4,
    parameter int CNT_W = 24
);
    logic             cfg_we;
    logic [3:0]       cfg_ch;
    logic [CNT_W-1:0] cfg_div;
    logic             cfg_mode;
    logic [NCH-1:0]   ch_en;
    logic [NCH-1:0]   start;
    logic [NCH-1:0]   tick;
    logic [NCH-1:0]   busy;
`ifdef TICK_GEN_SQUARE_EN
    logic [NCH-1:0]   sq_out;

    modport master (
        output cfg_we, cfg_ch, cfg_div, cfg_mode, ch_en, start,
        input  tick, busy, sq_out
    );

    modport slave (
        input  cfg_we, cfg_ch, cfg_div, cfg_mode, ch_en, start,
        output tick, busy, sq_out
    );
`else
    modport master (
        output cfg_we, cfg_ch, cfg_div, cfg_mode, ch_en, start,
        input  tick, busy
    );

    modport slave (
        input  cfg_we, cfg_ch, cfg_div, cfg_mode, ch_en, start,
        output tick, busy
    );
`endif
endinterface

// File: rtl/multi_tick_gen.sv
// rtl/multi_tick_gen.sv - NCH independent periodic/one-shot tick channels; TICK_GEN_SQUARE_EN adds a per-channel square-wave output
module multi_tick_gen #(
    parameter int               NCH         = 4,
    parameter int               CNT_W       = 24,
    parameter logic [CNT_W-1:0] DEFAULT_DIV = CNT_W'(32'd11_999_999)
) (
    input  logic              clk,
    input  logic              rst,
    multi_tick_gen_if.slave   tg_bus
);

    logic [NCH-1:0][CNT_W-1:0] r_div;
    logic [NCH-1:0][CNT_W-1:0] r_cnt;
    logic [NCH-1:0]            r_mode;
    logic [NCH-1:0]            r_tick;
    logic [NCH-1:0]            r_busy;
`ifdef TICK_GEN_SQUARE_EN
    logic [NCH-1:0]            r_sq;
`endif

    logic [NCH-1:0]            w_cfg_hit;
    logic [NCH-1:0]            w_at_div;

    // Decode which channel a config write targets (indices >= NCH match nothing) and flag terminal counts
    always_comb begin
        w_cfg_hit = '0;
        w_at_div  = '0;
        for (int ch = 0; ch < NCH; ch++) begin
            w_cfg_hit[ch] = tg_bus.cfg_we && (tg_bus.cfg_ch == 4'(ch));
            w_at_div[ch]  = (r_cnt[ch] == r_div[ch]);
        end
    end

    // Per-channel counter state; config write beats disable, which beats counting or start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int ch = 0; ch < NCH; ch++) begin
                r_div[ch]  <= DEFAULT_DIV;
                r_cnt[ch]  <= '0;
                r_mode[ch] <= 1'b0;
                r_tick[ch] <= 1'b0;
                r_busy[ch] <= 1'b0;
`ifdef TICK_GEN_SQUARE_EN
                r_sq[ch]   <= 1'b0;
`endif
            end
        end else begin
            for (int ch = 0; ch < NCH; ch++) begin
                if (w_cfg_hit[ch]) begin
                    r_div[ch]  <= tg_bus.cfg_div;
                    r_mode[ch] <= tg_bus.cfg_mode;
                    r_cnt[ch]  <= '0;
                    r_tick[ch] <= 1'b0;
                    r_busy[ch] <= 1'b0;
`ifdef TICK_GEN_SQUARE_EN
                    r_sq[ch]   <= 1'b0;
`endif
                end else if (!tg_bus.ch_en[ch]) begin
                    r_cnt[ch]  <= '0;
                    r_tick[ch] <= 1'b0;
                    r_busy[ch] <= 1'b0;
`ifdef TICK_GEN_SQUARE_EN
                    r_sq[ch]   <= 1'b0;
`endif
                end else if (!r_mode[ch]) begin
                    // Periodic: the counter only ever climbs to div, so it cannot wrap
                    r_busy[ch] <= 1'b0;
                    if (w_at_div[ch]) begin
                        r_cnt[ch]  <= '0;
                        r_tick[ch] <= 1'b1;
`ifdef TICK_GEN_SQUARE_EN
                        r_sq[ch]   <= ~r_sq[ch];
`endif
                    end else begin
                        r_cnt[ch]  <= r_cnt[ch] + 1'b1;
                        r_tick[ch] <= 1'b0;
                    end
                end else if (r_busy[ch]) begin
                    // One-shot in flight: further starts are ignored until the tick fires
                    if (w_at_div[ch]) begin
                        r_cnt[ch]  <= '0;
                        r_tick[ch] <= 1'b1;
                        r_busy[ch] <= 1'b0;
`ifdef TICK_GEN_SQUARE_EN
                        r_sq[ch]   <= ~r_sq[ch];
`endif
                    end else begin
                        r_cnt[ch]  <= r_cnt[ch] + 1'b1;
                        r_tick[ch] <= 1'b0;
                    end
                end else begin
                    // One-shot idle: arm on start, counting from zero
                    r_tick[ch] <= 1'b0;
                    r_cnt[ch]  <= '0;
                    if (tg_bus.start[ch]) begin
                        r_busy[ch] <= 1'b1;
                    end
                end
            end
        end
    end

    assign tg_bus.tick   = r_tick;
    assign tg_bus.busy   = r_busy;
`ifdef TICK_GEN_SQUARE_EN
    assign tg_bus.sq_out = r_sq;
`endif

endmodule

// File: tb/tb_multi_tick_gen.sv
// tb/tb_multi_tick_gen.sv - directed self-checking bench for multi_tick_gen with a per-cycle arithmetic reference model
module tb_multi_tick_gen;

    localparam int NCH     = 4;
    localparam int CNT_W   = 24;
    localparam int DEF_DIV = 11999999;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    multi_tick_gen_if #(.NCH(NCH), .CNT_W(CNT_W)) bus ();

    multi_tick_gen #(.NCH(NCH), .CNT_W(CNT_W)) dut (
        .clk    (clk),
        .rst    (rst),
        .tg_bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int n     = 0;

    // Model: a channel's timing is derived from the edge index where its count last restarted (o)
    // and, for one-shots, the edge index at which the start was accepted (s, -1 when idle).
    int             m_div  [NCH];
    bit             m_mode [NCH];
    int             m_o    [NCH];
    int             m_s    [NCH];
    logic [NCH-1:0] e_tick;
    logic [NCH-1:0] e_busy;
    logic [NCH-1:0] e_sq;

    function automatic void chk(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at edge %0d: got %0d expected %0d", name, n, act, exp);
        end
    endfunction

    function automatic void model_clear(int c);
        m_o[c]    = n;
        m_s[c]    = -1;
        e_tick[c] = 1'b0;
        e_busy[c] = 1'b0;
        e_sq[c]   = 1'b0;
    endfunction

    function automatic void model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_div[c]  = DEF_DIV;
            m_mode[c] = 1'b0;
            model_clear(c);
        end
    endfunction

    function automatic void model_update();
        for (int c = 0; c < NCH; c++) begin
            if (rst) begin
                m_div[c]  = DEF_DIV;
                m_mode[c] = 1'b0;
                model_clear(c);
            end else if (bus.cfg_we && int'(bus.cfg_ch) == c) begin
                m_div[c]  = int'(bus.cfg_div);
                m_mode[c] = bus.cfg_mode;
                model_clear(c);
            end else if (!bus.ch_en[c]) begin
                model_clear(c);
            end else if (!m_mode[c]) begin
                e_busy[c] = 1'b0;
                e_tick[c] = ((n - m_o[c]) % (m_div[c] + 1) == 0);
                if (e_tick[c]) e_sq[c] = ~e_sq[c];
            end else if (m_s[c] >= 0) begin
                if (n - m_s[c] == m_div[c] + 1) begin
                    e_tick[c] = 1'b1;
                    e_busy[c] = 1'b0;
                    e_sq[c]   = ~e_sq[c];
                    m_s[c]    = -1;
                end else begin
                    e_tick[c] = 1'b0;
                    e_busy[c] = 1'b1;
                end
            end else begin
                e_tick[c] = 1'b0;
                if (bus.start[c]) begin
                    m_s[c]    = n;
                    e_busy[c] = 1'b1;
                end else begin
                    e_busy[c] = 1'b0;
                end
            end
        end
    endfunction

    task automatic step();
        @(posedge clk);
        n++;
        model_update();
        @(negedge clk);
        chk("tick", int'(bus.tick), int'(e_tick));
        chk("busy", int'(bus.busy), int'(e_busy));
`ifdef TICK_GEN_SQUARE_EN
        chk("sq_out", int'(bus.sq_out), int'(e_sq));
`endif
    endtask

    task automatic cfg_write(input int ch, input int dv, input bit md);
        bus.cfg_we   = 1'b1;
        bus.cfg_ch   = 4'(ch);
        bus.cfg_div  = CNT_W'(dv);
        bus.cfg_mode = md;
        step();
        bus.cfg_we   = 1'b0;
    endtask

    int base, first_rel, cnt_t, last_rel, busy_cnt, seen, toggles;
    logic prev_sq;

    initial begin
        bus.cfg_we   = 1'b0;
        bus.cfg_ch   = '0;
        bus.cfg_div  = '0;
        bus.cfg_mode = 1'b0;
        bus.ch_en    = '0;
        bus.start    = '0;
        model_reset();
        #1;
        chk("reset_tick", int'(bus.tick), 0);
        chk("reset_busy", int'(bus.busy), 0);

        // Reset held with random inputs
        for (int i = 0; i < 6; i++) begin
            bus.cfg_we   = 1'($urandom_range(0, 1));
            bus.cfg_ch   = 4'($urandom_range(0, 15));
            bus.cfg_div  = CNT_W'($urandom_range(0, 3));
            bus.cfg_mode = 1'($urandom_range(0, 1));
            bus.ch_en    = 4'($urandom_range(0, 15));
            bus.start    = 4'($urandom_range(0, 15));
            step();
        end
        rst          = 1'b0;
        bus.cfg_we   = 1'b0;
        bus.ch_en    = '0;
        bus.start    = '0;
        for (int i = 0; i < 5; i++) step();

        // Periodic ch0, div=3
        cfg_write(0, 3, 1'b0);
        bus.ch_en[0] = 1'b1;
        base = n; first_rel = -1; cnt_t = 0; last_rel = -1;
        for (int i = 0; i < 13; i++) begin
            step();
            if (bus.tick[0]) begin
                if (first_rel < 0) first_rel = n - base;
                last_rel = n - base;
                cnt_t++;
            end
        end
        chk("p0_first_tick_edge", first_rel, 4);
        chk("p0_last_tick_edge", last_rel, 12);
        chk("p0_tick_count", cnt_t, 3);

        // Periodic ch1, div=0 -> continuous
        cfg_write(1, 0, 1'b0);
        bus.ch_en[1] = 1'b1;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            seen += int'(bus.tick[1]);
        end
        chk("div0_tick_cycles", seen, 4);
        bus.ch_en[1] = 1'b0;
        step();
        chk("div0_disable_tick", int'(bus.tick[1]), 0);

        // One-shot ch2, div=5, with an ignored second start
        cfg_write(2, 5, 1'b1);
        bus.ch_en[2] = 1'b1;
        step();
        bus.start[2] = 1'b1;
        step();
        busy_cnt = int'(bus.busy[2]); first_rel = -1; cnt_t = 0;
        for (int i = 1; i <= 8; i++) begin
            bus.start[2] = (i == 3);
            step();
            busy_cnt += int'(bus.busy[2]);
            if (bus.tick[2]) begin
                cnt_t++;
                first_rel = i;
            end
        end
        bus.start[2] = 1'b0;
        chk("os_busy_cycles", busy_cnt, 6);
        chk("os_tick_edge", first_rel, 6);
        chk("os_tick_count", cnt_t, 1);

        // Starts while disabled and in periodic mode are ignored
        cfg_write(3, 2, 1'b1);
        bus.start[3] = 1'b1;
        bus.start[0] = 1'b1;
        step();
        bus.start    = '0;
        chk("start_disabled_busy", int'(bus.busy[3]), 0);
        chk("start_periodic_busy", int'(bus.busy[0]), 0);

        // Mid-period rewrite of ch0 to div=7
        for (int i = 0; i < 8 && !bus.tick[0]; i++) step();
        step();
        step();
        cfg_write(0, 7, 1'b0);
        base = n; first_rel = -1;
        for (int i = 0; i < 12 && first_rel < 0; i++) begin
            step();
            if (bus.tick[0]) first_rel = n - base;
        end
        chk("rewrite_next_tick", first_rel, 8);

        // Out-of-range channel write is inert
        cfg_write(15, 1, 1'b1);
        for (int i = 0; i < 10; i++) step();

        // Config write and start in the same cycle on ch2
        bus.cfg_we   = 1'b1;
        bus.cfg_ch   = 4'd2;
        bus.cfg_div  = CNT_W'(2);
        bus.cfg_mode = 1'b1;
        bus.start[2] = 1'b1;
        step();
        bus.cfg_we   = 1'b0;
        bus.start[2] = 1'b0;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            seen += int'(bus.busy[2]) + int'(bus.tick[2]);
        end
        chk("cfg_wins_over_start", seen, 0);

        // ch0 div=1: tick every 2 cycles, square period 4
        cfg_write(0, 1, 1'b0);
        cnt_t = 0;
        toggles = 0;
`ifdef TICK_GEN_SQUARE_EN
        prev_sq = bus.sq_out[0];
`else
        prev_sq = 1'b0;
`endif
        for (int i = 0; i < 8; i++) begin
            step();
            cnt_t += int'(bus.tick[0]);
`ifdef TICK_GEN_SQUARE_EN
            if (bus.sq_out[0] != prev_sq) toggles++;
            prev_sq = bus.sq_out[0];
`endif
        end
        chk("div1_ticks_in_8", cnt_t, 4);
`ifdef TICK_GEN_SQUARE_EN
        chk("sq_toggles_in_8", toggles, 4);
`endif

        // Asynchronous reset mid-run
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("async_rst_tick", int'(bus.tick), 0);
        chk("async_rst_busy", int'(bus.busy), 0);
`ifdef TICK_GEN_SQUARE_EN
        chk("async_rst_sq", int'(bus.sq_out), 0);
`endif
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/multi_tick_gen.md
MULTI_TICK_GEN -- requirements
Module: multi_tick_gen

Interface
- REQ-001 Parameter NCH, default 4, number of independent tick channels (1..16).
- REQ-002 Parameter CNT_W, default 24, width of each channel's divisor and counter.
- REQ-003 Parameter DEFAULT_DIV, default 12000000-1 truncated to CNT_W bits, divisor loaded at reset.
- REQ-004 clk  input  1  clock.
- REQ-005 rst  input  1  reset, asynchronous, active-high.
- REQ-006 cfg_we  input  1  configuration write strobe, one cycle.
- REQ-007 cfg_ch  input  4  channel index for cfg_we.
- REQ-008 cfg_div  input  CNT_W  divisor value to load.
- REQ-009 cfg_mode  input  1  mode to load: 0 periodic, 1 one-shot.
- REQ-010 ch_en  input  NCH  per-channel enable, level.
- REQ-011 start  input  NCH  per-channel one-shot trigger, sampled each edge.
- REQ-012 tick  output  NCH  per-channel registered one-cycle tick.
- REQ-013 busy  output  NCH  per-channel one-shot in progress.

Function
- REQ-014 Each channel SHALL hold registers div[CNT_W], mode, cnt[CNT_W], busy and tick; channels are fully independent.
- REQ-015 Periodic, ch_en=1: at each edge, if cnt==div then tick<=1, cnt<=0; otherwise tick<=0, cnt<=cnt+1.
- REQ-016 Periodic period SHALL be div+1 cycles; the first tick appears after the (div+1)-th edge at which ch_en is sampled high from cnt=0; div=0 holds tick high continuously.
- REQ-017 ch_en=0 SHALL force cnt<=0, tick<=0, busy<=0 at the next edge.
- REQ-018 One-shot, ch_en=1, busy=0: start=1 sets busy<=1, cnt<=0, tick<=0.
- REQ-019 One-shot, busy=1: at the edge where cnt==div, tick<=1 and busy<=0; otherwise cnt<=cnt+1 and tick<=0; exactly one tick per start, asserted div+1 edges after the start edge.
- REQ-020 start while busy=1, while ch_en=0, or in periodic mode SHALL be ignored.
- REQ-021 cfg_we with cfg_ch<NCH SHALL load div and mode for that channel and clear cnt, tick and busy on the same edge; the new settings apply from the next edge.
- REQ-022 cfg_we and start on the same channel in the same cycle: the configuration write wins and start is dropped.
- REQ-023 cfg_we with cfg_ch>=NCH SHALL have no effect.
- REQ-024 The counter SHALL never exceed div; no wrap-around past 2^CNT_W-1 is reachable.

Reset
- REQ-025 rst=1 SHALL asynchronously set tick=0, busy=0, cnt=0, div=DEFAULT_DIV and mode=0 on all channels, including mid-count or mid-one-shot.
- REQ-026 After rst deasserts, the channels SHALL behave as freshly enabled, starting from cnt=0.

Configuration
- REQ-027 Macro TICK_GEN_SQUARE_EN defined: an additional output sq_out[NCH] SHALL toggle on each edge where the channel's tick is set, giving a square wave of period 2*(div+1) cycles; it is reset to 0 by rst, cleared by ch_en=0, and cleared by a cfg write to that channel.
- REQ-028 Macro TICK_GEN_SQUARE_EN undefined: sq_out SHALL be absent from the port list and no toggle logic SHALL be built.

Verification
- REQ-029 Hold rst high with random inputs -> tick=0 and busy=0 throughout; after release with ch_en=0, tick stays 0.
- REQ-030 Write ch0 div=3, mode=0, then hold ch_en[0]=1 -> tick[0] high on edges 4, 8, 12, ... counted from enable, one cycle each; other channels silent.
- REQ-031 Write ch1 div=0, mode=0, with ch_en[1]=1 -> tick[1] continuously high; drop ch_en[1] -> tick[1]=0 on the next edge.
- REQ-032 Write ch2 div=5, mode=1, with ch_en[2]=1, then pulse start[2] -> busy[2] high for 6 cycles, a single tick[2] on the 6th edge after start; a second start at cycle 3 is ignored.
- REQ-033 Midway through a ch0 period, write div=7 -> cnt cleared and next tick 8 edges later; a write with cfg_ch=15 and NCH=4 changes nothing; cfg_we and start on the same cycle -> no one-shot.
- REQ-034 With TICK_GEN_SQUARE_EN defined and div=1 -> sq_out toggles every 2 cycles (period 4); assert rst mid-run -> sq_out=0 immediately.
